// File: rtl/co_fetch_seq_if.sv
// Start/status, ROM read port and coefficient stream of the coefficient fetch sequencer.
interface co_fetch_seq_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   len_i;
  logic              busy_o;
  logic              done_o;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [DATA_W-1:0] coef_o;
  logic              coef_val_o;
  logic              coef_rdy_i;
  logic              coef_last_o;

  modport slave (
    input  start_i, base_addr_i, len_i, rom_data_i, coef_rdy_i,
    output busy_o, done_o, rom_en_o, rom_addr_o, coef_o, coef_val_o, coef_last_o
  );

  modport master (
    output start_i, base_addr_i, len_i, rom_data_i, coef_rdy_i,
    input  busy_o, done_o, rom_en_o, rom_addr_o, coef_o, coef_val_o, coef_last_o
  );
endinterface

// File: rtl/co_fetch_seq.sv
// Issues consecutive coefficient ROM reads under a credit limit, absorbs the ROM latency
// and streams the returned words through a small first-word-fall-through FIFO.
module co_fetch_seq #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  co_fetch_seq_if.slave bus
);
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + ROM_LAT + 1);
  localparam int unsigned ENT_W = DATA_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ROM_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [ROM_LAT-1:0] last_sr_q, last_sr_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  inflight_c;
  logic              done_q, done_d;
  logic              accept_c, zero_start_c, issue_c, push_c, pop_c, empty_c, credit_ok_c;
  logic [ENT_W-1:0]  head_c;

  // Reads already issued whose data has not yet reached the FIFO
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight_c = inflight_c + CNT_W'(vld_sr_q[i]);
    end
  end

  assign empty_c     = (count_q == '0);
  assign head_c      = mem_q[rd_ptr_q];
  assign credit_ok_c = (count_q + inflight_c) < CNT_W'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = ISSUE;
      ISSUE:   if (issue_c && (rem_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (pop_c && head_c[DATA_W]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    zero_start_c = (state_q == IDLE) && bus.start_i && (bus.len_i == '0);
    accept_c     = (state_q == IDLE) && bus.start_i && (bus.len_i != '0);
    issue_c      = (state_q == ISSUE) && credit_ok_c;
    push_c       = vld_sr_q[ROM_LAT-1];
    pop_c        = !empty_c && bus.coef_rdy_i;
    done_d       = zero_start_c || ((state_q == DRAIN) && pop_c && head_c[DATA_W]);
    addr_d       = addr_q;
    rem_d        = rem_q;
    last_addr_d  = last_addr_q;
    if (accept_c) begin
      addr_d = bus.base_addr_i;
      rem_d  = bus.len_i;
    end else if (issue_c) begin
      addr_d      = addr_q + ADDR_W'(1);
      rem_d       = rem_q - LEN_W'(1);
      last_addr_d = addr_q;
    end
    // Tag pipeline mirrors the ROM latency; bit 0 is the read issued this cycle
    vld_sr_d     = vld_sr_q << 1;
    last_sr_d    = last_sr_q << 1;
    vld_sr_d[0]  = issue_c;
    last_sr_d[0] = issue_c && (rem_q == LEN_W'(1));
    count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rem_q       <= rem_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= {last_sr_q[ROM_LAT-1], bus.rom_data_i};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done_q;
  assign bus.rom_en_o    = (state_q != IDLE);
  assign bus.rom_addr_o  = issue_c ? addr_q : last_addr_q;
  assign bus.coef_o      = head_c[DATA_W-1:0];
  assign bus.coef_last_o = head_c[DATA_W];
  assign bus.coef_val_o  = !empty_c;
endmodule

// File: tb/tb_co_fetch_seq.sv
// Scenario bench for co_fetch_seq: address-echo ROM model, expected-word queue per run.
module tb_co_fetch_seq;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ROM_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct {int data; bit last;} exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  co_fetch_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  co_fetch_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // ROM model: content = address, fixed latency; non-enabled cycles return junk
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_en_o ? DATA_W'(bus.rom_addr_o) : 16'hDEAD;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_data_i = rom_pipe[ROM_LAT-1];

  bit ovf_bad, bound_bad;
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(dut.count_q) + int'(dut.inflight_c) > int'(FIFO_DEPTH)) bound_bad = 1'b1;
      if (dut.push_c && int'(dut.count_q) == int'(FIFO_DEPTH)) ovf_bad = 1'b1;
    end
  end

  int   pass_cnt, chk_cnt;
  exp_t exp_q[$];
  int   obs_d[$];
  bit   obs_l[$];
  int   done_at, first_val, first_en, en_cnt, n_done;
  bit   val_seen, busy_at_done, timed_out;

  task automatic start_run(input int base, input int len, input bit track);
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.base_addr_i = ADDR_W'(base);
    bus.len_i       = (ADDR_W+1)'(len);
    if (track) for (int i = 0; i < len; i++) exp_q.push_back('{(base + i) % 1024, i == len - 1});
  endtask

  // Runs cycles until done_o (+post cycles), recording stream handshakes; no judging here
  task automatic collect(input int budget, input int mode, input int inj_cyc, input int post);
    obs_d.delete(); obs_l.delete();
    done_at = -1; first_val = -1; first_en = -1; en_cnt = 0; n_done = 0;
    val_seen = 0; busy_at_done = 0; timed_out = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.start_i = (c == inj_cyc);
      if (c == inj_cyc) begin
        bus.base_addr_i = 10'd600;
        bus.len_i       = 11'd5;
      end
      if (mode == 0) bus.coef_rdy_i = 1'b1;
      else bus.coef_rdy_i = (c >= 20 && c < 30) ? 1'b0 : ((c % 4 == 0) || (c % 4 == 3));
      if (bus.rom_en_o) begin en_cnt++; if (first_en < 0) first_en = c; end
      if (bus.coef_val_o) begin val_seen = 1; if (first_val < 0) first_val = c; end
      if (bus.coef_val_o && bus.coef_rdy_i) begin
        obs_d.push_back(int'(bus.coef_o));
        obs_l.push_back(bus.coef_last_o);
      end
      if (bus.done_o) begin
        n_done++;
        if (done_at < 0) begin done_at = c; busy_at_done = bus.busy_o; end
      end
      if (done_at >= 0 && c >= done_at + post) begin timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({bus.busy_o, bus.done_o, bus.rom_en_o, bus.coef_val_o, bus.coef_last_o} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.busy_o, bus.done_o, bus.rom_en_o, bus.coef_val_o, bus.coef_last_o});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({bus.rom_addr_o, bus.coef_o} !== '0)
      $display("FAIL reset_data: got addr %0d coef %0d expected 0 0", bus.rom_addr_o, bus.coef_o);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    exp_t e;
    start_run(5, 8, 1);
    collect(60, 0, -1, 3);
    chk_cnt++; if (timed_out !== 1'b0) $display("FAIL basic_timeout: got %0d expected 0", timed_out); else pass_cnt++;
    chk_cnt++; if (first_en !== 0) $display("FAIL basic_first_en: got %0d expected 0", first_en); else pass_cnt++;
    chk_cnt++; if (first_val !== ROM_LAT + 1) $display("FAIL basic_first_val: got %0d expected %0d", first_val, ROM_LAT + 1); else pass_cnt++;
    chk_cnt++; if (done_at !== 11) $display("FAIL basic_done_cycle: got %0d expected 11", done_at); else pass_cnt++;
    chk_cnt++; if (n_done !== 1 || busy_at_done !== 1'b0) $display("FAIL basic_done_busy: got done %0d busy %0d expected 1 0", n_done, busy_at_done); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL basic_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL basic_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (obs_d.size() !== 0) $display("FAIL basic_extra: got %0d expected 0", obs_d.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    exp_t e;
    start_run(1020, 6, 1);
    collect(60, 0, -1, 2);
    chk_cnt++; if (obs_d.size() !== 6 || timed_out) $display("FAIL wrap_count: got %0d expected 6", obs_d.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL wrap_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL wrap_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    start_run(40, 16, 1);
    collect(200, 1, -1, 2);
    chk_cnt++; if (obs_d.size() !== 16 || timed_out) $display("FAIL bp_count: got %0d expected 16", obs_d.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL bp_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL bp_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (bound_bad !== 1'b0) $display("FAIL bp_credit_bound: got %0d expected 0", bound_bad); else pass_cnt++;
    chk_cnt++; if (ovf_bad !== 1'b0) $display("FAIL bp_push_full: got %0d expected 0", ovf_bad); else pass_cnt++;
  endtask

  task automatic test_edge_lengths();
    exp_t e;
    start_run(5, 0, 1);
    collect(10, 0, -1, 3);
    chk_cnt++; if (done_at !== 0 || n_done !== 1) $display("FAIL len0_done: got at %0d n %0d expected 0 1", done_at, n_done); else pass_cnt++;
    chk_cnt++; if (en_cnt !== 0 || val_seen !== 1'b0 || busy_at_done !== 1'b0)
      $display("FAIL len0_quiet: got en %0d val %0d busy %0d expected 0 0 0", en_cnt, val_seen, busy_at_done); else pass_cnt++;
    start_run(77, 1, 1);
    collect(30, 0, -1, 2);
    chk_cnt++;
    if (obs_d.size() !== 1) $display("FAIL len1_count: got %0d expected 1", obs_d.size());
    else if (obs_d[0] !== 77 || obs_l[0] !== 1'b1) $display("FAIL len1_word: got %0d/%0d expected 77/1", obs_d[0], obs_l[0]);
    else pass_cnt++;
    exp_q.delete();
    start_run(0, 1024, 1);
    collect(1200, 0, -1, 2);
    chk_cnt++; if (obs_d.size() !== 1024 || timed_out) $display("FAIL len1024_count: got %0d expected 1024", obs_d.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL len1024_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL len1024_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int stale;
    bus.coef_rdy_i = 1'b0;
    start_run(200, 20, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++; if (bus.coef_val_o !== 1'b1 || bus.busy_o !== 1'b1) $display("FAIL rmr_pre: got val %0d busy %0d expected 1 1", bus.coef_val_o, bus.busy_o); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.busy_o, bus.done_o, bus.rom_en_o, bus.coef_val_o, bus.coef_last_o, bus.rom_addr_o, bus.coef_o} !== '0)
      $display("FAIL rmr_outputs: got busy %0d en %0d val %0d addr %0d coef %0d expected all 0",
               bus.busy_o, bus.rom_en_o, bus.coef_val_o, bus.rom_addr_o, bus.coef_o);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.coef_rdy_i = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.coef_val_o || bus.busy_o) stale++;
    end
    chk_cnt++; if (stale !== 0) $display("FAIL rmr_stale: got %0d expected 0", stale); else pass_cnt++;
    start_run(100, 3, 1);
    collect(40, 0, -1, 2);
    chk_cnt++; if (obs_d.size() !== 3 || timed_out) $display("FAIL rmr_count: got %0d expected 3", obs_d.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL rmr_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL rmr_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    start_run(300, 10, 1);
    collect(60, 0, 4, 3);
    chk_cnt++; if (obs_d.size() !== 10 || n_done !== 1) $display("FAIL swb_count: got %0d words %0d done expected 10 1", obs_d.size(), n_done); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL swb_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL swb_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
    // Restart in the very cycle done_o pulses
    start_run(50, 2, 0);
    collect(40, 0, -1, 0);
    chk_cnt++; if (bus.done_o !== 1'b1 || obs_d.size() !== 2) $display("FAIL swb_first_run: got done %0d words %0d expected 1 2", bus.done_o, obs_d.size()); else pass_cnt++;
    bus.start_i     = 1'b1;
    bus.base_addr_i = 10'd70;
    bus.len_i       = 11'd2;
    for (int i = 0; i < 2; i++) exp_q.push_back('{70 + i, i == 1});
    collect(40, 0, -1, 2);
    chk_cnt++; if (first_val !== ROM_LAT + 1 || obs_d.size() !== 2) $display("FAIL swb_done_start: got first %0d words %0d expected %0d 2", first_val, obs_d.size(), ROM_LAT + 1); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_d.size() == 0) $display("FAIL swb_done_word: got none expected %0d", e.data);
      else begin
        int d; bit l;
        d = obs_d.pop_front(); l = obs_l.pop_front();
        if (d !== e.data || l !== e.last) $display("FAIL swb_done_word: got %0d/%0d expected %0d/%0d", d, l, e.data, e.last);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i = '0;
    bus.coef_rdy_i = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge_lengths();
    test_reset_mid_run();
    test_start_while_busy();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1);
  end
endmodule
